// File: rtl/count_run_sequencer_if.sv
// Host and counter-datapath signals of the count run sequencer, grouped as one bus.
interface count_run_sequencer_if #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned REP_W = 4
);
  logic             start;
  logic             abort;
  logic [WIDTH-1:0] limit;
  logic [REP_W-1:0] repeats;
  logic [WIDTH-1:0] cnt_q;
  logic             cnt_clear;
  logic             cnt_en;
  logic             busy;
  logic             wrap;
  logic             done;
  logic [REP_W-1:0] run_idx;

  // Host / datapath side
  modport master (
    output start, abort, limit, repeats, cnt_q,
    input  cnt_clear, cnt_en, busy, wrap, done, run_idx
  );

  // Sequencer side
  modport slave (
    input  start, abort, limit, repeats, cnt_q,
    output cnt_clear, cnt_en, busy, wrap, done, run_idx
  );
endinterface

// File: rtl/count_run_sequencer.sv
// Sequences an external up-counter through repeated clear/count runs up to a latched limit.
module count_run_sequencer #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned REP_W = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  count_run_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_RUN   = 3'd2,
    S_WRAP  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] lim_q, lim_d;
  logic [REP_W-1:0] rep_q, rep_d;
  logic [REP_W-1:0] run_idx_q, run_idx_d;

  // State and latched run parameters
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      lim_q     <= '0;
      rep_q     <= '0;
      run_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      lim_q     <= lim_d;
      rep_q     <= rep_d;
      run_idx_q <= run_idx_d;
    end
  end

  // Next-state logic; abort wins over every other transition in active states
  always_comb begin
    state_d   = state_q;
    lim_d     = lim_q;
    rep_d     = rep_q;
    run_idx_d = run_idx_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          lim_d     = bus.limit;
          rep_d     = bus.repeats;
          run_idx_d = '0;
          state_d   = S_CLEAR;
        end
      end
      S_CLEAR: begin
        if (bus.abort) state_d = S_IDLE;
        else           state_d = S_RUN;
      end
      S_RUN: begin
        if (bus.abort)               state_d = S_IDLE;
        else if (bus.cnt_q == lim_q) state_d = S_WRAP;
      end
      S_WRAP: begin
        if (bus.abort) begin
          state_d = S_IDLE;
        end else if (run_idx_q == rep_q) begin
          state_d = S_DONE;
        end else begin
          run_idx_d = run_idx_q + REP_W'(1);
          state_d   = S_CLEAR;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Moore decodes; enable stops combinationally once the counter reaches the limit
  assign bus.busy      = (state_q == S_CLEAR) || (state_q == S_RUN) || (state_q == S_WRAP);
  assign bus.cnt_clear = (state_q == S_CLEAR);
  assign bus.wrap      = (state_q == S_WRAP);
  assign bus.done      = (state_q == S_DONE);
  assign bus.cnt_en    = (state_q == S_RUN) && (bus.cnt_q != lim_q);
  assign bus.run_idx   = run_idx_q;

endmodule

// File: tb/tb_count_run_sequencer.sv
// Bench for count_run_sequencer: per-cycle expected trace built from the run rules.
module tb_count_run_sequencer;

  typedef struct packed {
    logic       busy;
    logic       clear;
    logic       en;
    logic       wrap;
    logic       done;
    logic [3:0] idx;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] cnt = 4'd0;

  count_run_sequencer_if #(.WIDTH(4), .REP_W(4)) bus ();

  count_run_sequencer #(.WIDTH(4), .REP_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  // Counter datapath model
  always @(posedge clk) begin
    if (bus.cnt_clear)   cnt <= 4'd0;
    else if (bus.cnt_en) cnt <= cnt + 4'd1;
  end
  assign bus.cnt_q = cnt;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  int   acc_cyc = 0;
  int   exp_lat = 0;
  bit   lat_pending = 1'b0;
  logic [3:0] last_idx = 4'd0;
  exp_t cur;
  exp_t exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", tag, cyc, got, exp);
    end
  endtask

  function automatic exp_t mk(input logic b, input logic c, input logic e,
                              input logic w, input logic d, input logic [3:0] i);
    exp_t x;
    x.busy = b; x.clear = c; x.en = e; x.wrap = w; x.done = d; x.idx = i;
    return x;
  endfunction

  // One clock cycle: check current outputs, drive inputs, advance the model
  task automatic step(input bit s, input bit a, input logic [3:0] l, input logic [3:0] r);
    exp_t nxt;
    check("busy",      32'(bus.busy),      32'(cur.busy));
    check("cnt_clear", 32'(bus.cnt_clear), 32'(cur.clear));
    check("cnt_en",    32'(bus.cnt_en),    32'(cur.en));
    check("wrap",      32'(bus.wrap),      32'(cur.wrap));
    check("done",      32'(bus.done),      32'(cur.done));
    check("run_idx",   32'(bus.run_idx),   32'(cur.idx));
    if (bus.done && lat_pending) begin
      check("done_latency", 32'(cyc - acc_cyc), 32'(exp_lat));
      lat_pending = 1'b0;
    end
    bus.start   = s;
    bus.abort   = a;
    bus.limit   = l;
    bus.repeats = r;
    if (!cur.busy && !cur.done && s) begin
      exp_q.delete();
      for (int rr = 0; rr <= int'(r); rr++) begin
        exp_q.push_back(mk(1, 1, 0, 0, 0, 4'(rr)));
        for (int k = 0; k <= int'(l); k++)
          exp_q.push_back(mk(1, 0, (k < int'(l)), 0, 0, 4'(rr)));
        exp_q.push_back(mk(1, 0, 0, 1, 0, 4'(rr)));
      end
      exp_q.push_back(mk(0, 0, 0, 0, 1, r));
      last_idx    = r;
      acc_cyc     = cyc;
      exp_lat     = (int'(r) + 1) * (int'(l) + 3) + 1;
      lat_pending = 1'b1;
    end else if (cur.busy && a) begin
      exp_q.delete();
      last_idx    = cur.idx;
      lat_pending = 1'b0;
    end
    if (exp_q.size() > 0) nxt = exp_q.pop_front();
    else                  nxt = mk(0, 0, 0, 0, 0, last_idx);
    @(posedge clk);
    @(negedge clk);
    cur = nxt;
    cyc++;
  endtask

  // Full sequence; with ign set, start is held high and limit scrambled while active
  task automatic run_seq(input logic [3:0] l, input logic [3:0] r, input bit ign);
    int n;
    n = (int'(r) + 1) * (int'(l) + 3) + 2;
    step(1'b1, 1'b0, l, r);
    for (int i = 0; i < n; i++)
      step(ign && (cur.busy || cur.done), 1'b0, ign ? 4'($urandom) : l, r);
  endtask

  initial begin
    bus.start = 1'b0; bus.abort = 1'b0; bus.limit = 4'd0; bus.repeats = 4'd0;
    cur = mk(0, 0, 0, 0, 0, 4'd0);
    @(negedge clk);
    @(negedge clk);
    check("rst_busy",    32'(bus.busy),    32'd0);
    check("rst_run_idx", 32'(bus.run_idx), 32'd0);
    reset = 1'b0;
    step(0, 0, 0, 0);
    step(0, 1, 4'd7, 4'd2);

    // Single run, then cnt must rest at the limit
    run_seq(4'd3, 4'd0, 1'b0);
    check("cnt_final_single", 32'(cnt), 32'd3);
    // Multi-run and edge limits
    run_seq(4'd3, 4'd1, 1'b0);
    run_seq(4'd0, 4'd2, 1'b0);
    run_seq(4'd15, 4'd0, 1'b0);
    check("cnt_final_max", 32'(cnt), 32'd15);

    // Abort while counter sits at 4, then a clean restart
    step(1, 0, 4'd9, 4'd0);
    for (int i = 0; i < 40 && !(cur.busy && !cur.clear && !cur.wrap && cnt == 4'd4); i++)
      step(0, 0, 4'd9, 4'd0);
    check("abort_reached_q4", 32'(cnt), 32'd4);
    step(0, 1, 4'd9, 4'd0);
    step(0, 0, 4'd9, 4'd0);
    step(0, 0, 4'd9, 4'd0);
    run_seq(4'd2, 4'd0, 1'b0);
    check("cnt_after_restart", 32'(cnt), 32'd2);

    // Start and limit changes while active must be ignored
    run_seq(4'd4, 4'd1, 1'b1);
    step(0, 0, 0, 0);

    // Async reset mid-run with run_idx already advanced
    step(1, 0, 4'd5, 4'd2);
    for (int i = 0; i < 60 && !(cur.idx == 4'd1 && cur.en && cnt == 4'd2); i++)
      step(0, 0, 4'd5, 4'd2);
    check("pre_reset_idx", 32'(bus.run_idx), 32'd1);
    #2 reset = 1'b1;
    #1;
    check("arst_busy",      32'(bus.busy),      32'd0);
    check("arst_cnt_en",    32'(bus.cnt_en),    32'd0);
    check("arst_cnt_clear", 32'(bus.cnt_clear), 32'd0);
    check("arst_run_idx",   32'(bus.run_idx),   32'd0);
    @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
    last_idx    = 4'd0;
    lat_pending = 1'b0;
    cur = mk(0, 0, 0, 0, 0, 4'd0);
    for (int i = 0; i < 4; i++) step(0, 0, 4'd5, 4'd2);

    // Random traffic
    for (int i = 0; i < 1500; i++)
      step(($urandom_range(0, 3) == 0), ($urandom_range(0, 39) == 0),
           4'($urandom), 4'($urandom_range(0, 3)));
    for (int i = 0; i < 80; i++) step(0, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
